// File: rtl/ecd_pkg.sv
// Shared types for the ecd encoder slot path.
package ecd_pkg;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_e;

  localparam int ECD_DATA_WIDTH = 64;

  typedef struct packed {
    logic signed [ECD_DATA_WIDTH-1:0] re;
    logic signed [ECD_DATA_WIDTH-1:0] im;
  } cplx_t;
endpackage

// File: rtl/ecd_rarg_bank.sv
// One ping-pong bank: 1W1R synchronous RAM with a single-cycle registered read.
module ecd_rarg_bank #(
  parameter int ADDR_WIDTH = 12,
  parameter int WORD_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WORD_WIDTH-1:0] rd_data
);
  logic [WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/ecd_rarg_buf.sv
// Ping-pong slot buffer: scatters permuted (optionally conjugated) slots into one bank
// while the other bank streams out in natural order through a 2-entry skid buffer.
module ecd_rarg_buf
  import ecd_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int POLY_POWER = 8192
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rarg_vld,
  output logic                  rarg_rdy,
  input  logic                  wr_vld,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_b_im,
  input  logic [DATA_WIDTH-1:0] wr_re,
  input  logic [DATA_WIDTH-1:0] wr_im,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_re,
  output logic [DATA_WIDTH-1:0] out_im,
  output logic                  out_last
);
  localparam int WORD_W = 2 * DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] BANK_N  = (ADDR_WIDTH+1)'(POLY_POWER / 2);
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic signed [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] S_MAX = ~S_MIN;

  function automatic logic signed [DATA_WIDTH-1:0] neg_sat(input logic signed [DATA_WIDTH-1:0] x);
    return (x == S_MIN) ? S_MAX : -x;
  endfunction

  bank_st_e                     bank_st [2];
  logic                         wbank, rbank, rdy_en, rd_active;
  logic [ADDR_WIDTH:0]          issue_cnt, wr_cnt, rd_cnt;
  logic                         issue_hs, wr_en, wr_full;
  logic                         rd_start, rd_issue, pop, last_hs, head_take, skid_load;
  logic [ADDR_WIDTH-1:0]        rd_addr;
  logic [1:0]                   fifo_lvl;
  logic signed [DATA_WIDTH-1:0] wr_im_c;
  logic [WORD_W-1:0]            wr_word, rd_word_sel;
  logic [WORD_W-1:0]            rd_word [2];
  logic                         rd_vld_p0, rd_last_p0, rd_bank_p0;
  logic [WORD_W-1:0]            skid_p1;
  logic                         skid_vld_p1, skid_last_p1;

  assign rarg_rdy = rdy_en & ((bank_st[wbank] == EMPTY) | (bank_st[wbank] == FILLING))
                  & (issue_cnt < BANK_N);
  assign issue_hs = rarg_vld & rarg_rdy;
  assign wr_en    = wr_vld & (bank_st[wbank] == FILLING);
  assign wr_full  = wr_en & (wr_cnt == BANK_N - CNT_ONE);
  assign wr_im_c  = wr_b_im ? neg_sat(wr_im) : wr_im;
  assign wr_word  = {wr_re, wr_im_c};

  // Read issue: credit counts head, skid and the in-flight RAM read.
  assign pop       = out_vld & out_rdy;
  assign last_hs   = pop & out_last;
  assign fifo_lvl  = 2'(out_vld) + 2'(skid_vld_p1) + 2'(rd_vld_p0);
  assign rd_start  = ~rd_active & (bank_st[rbank] == FULL);
  assign rd_issue  = (rd_start | (rd_active & (rd_cnt < BANK_N))) & (fifo_lvl <= 2'd1 + 2'(pop));
  assign rd_addr   = rd_start ? '0 : rd_cnt[ADDR_WIDTH-1:0];
  assign head_take = ~out_vld | pop;
  assign skid_load = rd_vld_p0 & out_vld & (~pop | skid_vld_p1);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ecd_rarg_bank #(.ADDR_WIDTH(ADDR_WIDTH), .WORD_WIDTH(WORD_W)) u_bank (
      .clk     (clk),
      .wr_en   (wr_en & (wbank == 1'(b))),
      .wr_addr (wr_addr),
      .wr_data (wr_word),
      .rd_en   (rd_issue & (rbank == 1'(b))),
      .rd_addr (rd_addr),
      .rd_data (rd_word[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      wbank      <= 1'b0;
      rbank      <= 1'b0;
      rdy_en     <= 1'b0;
      rd_active  <= 1'b0;
      issue_cnt  <= '0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      rd_vld_p0  <= 1'b0;
      rd_last_p0 <= 1'b0;
      rd_bank_p0 <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (issue_hs && bank_st[wbank] == EMPTY) bank_st[wbank] <= FILLING;
      if (wr_en) wr_cnt <= wr_cnt + CNT_ONE;
      if (wr_full) begin
        bank_st[wbank] <= FULL;
        wbank          <= ~wbank;
        wr_cnt         <= '0;
        issue_cnt      <= '0;
      end else if (issue_hs) begin
        issue_cnt <= issue_cnt + CNT_ONE;
      end
      if (rd_start) begin
        bank_st[rbank] <= DRAINING;
        rd_active      <= 1'b1;
      end
      if (last_hs) begin
        bank_st[rbank] <= EMPTY;
        rbank          <= ~rbank;
        rd_active      <= 1'b0;
      end
      rd_cnt    <= (rd_start ? '0 : rd_cnt) + (ADDR_WIDTH+1)'(rd_issue);
      rd_vld_p0 <= rd_issue;
      if (rd_issue) begin
        rd_last_p0 <= (rd_addr == '1);
        rd_bank_p0 <= rbank;
      end
    end
  end

  // p0 -> p1: RAM word lands in the output head or the skid entry.
  assign rd_word_sel = rd_word[rd_bank_p0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld      <= 1'b0;
      out_last     <= 1'b0;
      out_re       <= '0;
      out_im       <= '0;
      skid_vld_p1  <= 1'b0;
      skid_last_p1 <= 1'b0;
    end else begin
      if (head_take) begin
        out_vld <= skid_vld_p1 | rd_vld_p0;
        if (skid_vld_p1) begin
          {out_re, out_im} <= skid_p1;
          out_last         <= skid_last_p1;
        end else if (rd_vld_p0) begin
          {out_re, out_im} <= rd_word_sel;
          out_last         <= rd_last_p0;
        end else begin
          out_last <= 1'b0;
        end
      end
      if (skid_load) begin
        skid_vld_p1  <= 1'b1;
        skid_last_p1 <= rd_last_p0;
      end else if (head_take) begin
        skid_vld_p1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (skid_load) skid_p1 <= rd_word_sel;
  end
endmodule

// File: tb/tb_ecd_rarg_buf.sv
// Bench for ecd_rarg_buf: directed and random slot fills against a bank-image scoreboard.
module tb_ecd_rarg_buf;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rarg_vld = 1'b0;
  logic          rarg_rdy;
  logic          wr_vld = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic          wr_b_im = 1'b0;
  logic [DW-1:0] wr_re = '0;
  logic [DW-1:0] wr_im = '0;
  logic          out_vld;
  logic          out_rdy = 1'b1;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic          out_last;

  ecd_rarg_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .POLY_POWER(16)) dut (
    .clk(clk), .rst_n(rst_n), .rarg_vld(rarg_vld), .rarg_rdy(rarg_rdy),
    .wr_vld(wr_vld), .wr_addr(wr_addr), .wr_b_im(wr_b_im), .wr_re(wr_re), .wr_im(wr_im),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_re(out_re), .out_im(out_im), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          last;
  } beat_t;

  int            total = 0;
  int            bad = 0;
  int            rdy_mode = 0;
  beat_t         expq [$];
  logic [DW-1:0] img_re [NB];
  logic [DW-1:0] img_im [NB];
  int            fill_n = 0;
  logic [AW-1:0] slot_addr [16];
  logic [DW-1:0] slot_re [16];
  logic [DW-1:0] slot_im [16];
  logic          slot_b [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] conj_im(input logic [DW-1:0] im, input logic b);
    int v;
    if (!b) return im;
    v = -int'($signed(im));
    if (v > 32767) v = 32767;
    return DW'(v);
  endfunction

  // Scoreboard: each completed fill of NB writes becomes NB beats in address order.
  task automatic model_write(input int idx);
    img_re[slot_addr[idx]] = slot_re[idx];
    img_im[slot_addr[idx]] = conj_im(slot_im[idx], slot_b[idx]);
    fill_n++;
    if (fill_n == NB) begin
      for (int a = 0; a < NB; a++) expq.push_back('{re: img_re[a], im: img_im[a], last: (a == NB-1)});
      fill_n = 0;
    end
  endtask

  task automatic step();
    if (rdy_mode != 0) out_rdy = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
  endtask

  // Acts as ecd_addr_gen: write beat follows its rarg handshake by one cycle.
  task automatic run_slots(input int n);
    int k, pk, guard;
    logic pend, hs;
    k = 0; pk = 0; guard = 0; pend = 1'b0;
    while ((k < n || pend) && guard < 200) begin
      rarg_vld = (k < n);
      wr_vld   = pend;
      if (pend) begin
        wr_addr = slot_addr[pk]; wr_re = slot_re[pk]; wr_im = slot_im[pk]; wr_b_im = slot_b[pk];
      end
      if (rdy_mode != 0) out_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      hs = rarg_vld & rarg_rdy;
      @(posedge clk); #1;
      if (pend) model_write(pk);
      pend = hs;
      pk = k;
      if (hs) k++;
      guard++;
    end
    rarg_vld = 1'b0;
    wr_vld   = 1'b0;
    chk("slots_issued", k, n);
  endtask

  task automatic fill_random(input int n);
    int j;
    logic [AW-1:0] t;
    for (int base = 0; base < n; base += NB) begin
      for (int i = 0; i < NB; i++) slot_addr[base+i] = AW'(i);
      for (int i = NB-1; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = slot_addr[base+i]; slot_addr[base+i] = slot_addr[base+j]; slot_addr[base+j] = t;
      end
      for (int i = 0; i < NB; i++) begin
        slot_re[base+i] = DW'($urandom);
        slot_im[base+i] = DW'($urandom);
        slot_b[base+i]  = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic wait_drain(input int limit);
    int c;
    c = 0;
    while (expq.size() != 0 && c < limit) begin
      step();
      c++;
    end
    chk("drain_done", expq.size(), 0);
  endtask

  // Output monitor: head must match the next expected beat, stay put under stall, no bubbles mid-bank.
  logic prev_stall = 1'b0;
  logic prev_go = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_go    = 1'b0;
    end else begin
      if (prev_stall || prev_go) chk("no_bubble", out_vld, 1);
      if (out_vld) begin
        if (expq.size() == 0) chk("stale_beat", out_vld, 0);
        else begin
          chk("out_re", out_re, expq[0].re);
          chk("out_im", out_im, expq[0].im);
          chk("out_last", out_last, expq[0].last);
          if (out_rdy) void'(expq.pop_front());
        end
      end
      prev_stall = out_vld & ~out_rdy;
      prev_go    = out_vld & out_rdy & ~out_last;
    end
  end

  initial begin
    int perm [8] = '{3, 6, 1, 4, 7, 2, 5, 0};
    int c;
    logic found;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    chk("rst_rarg_rdy", rarg_rdy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_rel_0", rarg_rdy, 0);
    @(negedge clk);
    chk("rdy_rel_1", rarg_rdy, 1);
    @(posedge clk); #1;

    // 1: natural order, first-beat latency
    for (int k = 0; k < 8; k++) begin
      slot_addr[k] = AW'(k); slot_re[k] = DW'(k); slot_im[k] = DW'(k + 100); slot_b[k] = 1'b0;
    end
    run_slots(8);
    @(negedge clk); chk("lat_c1", out_vld, 0);
    @(negedge clk); chk("lat_c2", out_vld, 0);
    @(negedge clk); chk("lat_c3", out_vld, 1);
    wait_drain(60);

    // 2: permuted scatter, conjugate on odd slots
    for (int k = 0; k < 8; k++) begin
      slot_addr[k] = AW'(perm[k]); slot_re[k] = DW'($urandom); slot_im[k] = DW'($urandom);
      slot_b[k] = 1'(k % 2);
    end
    run_slots(8);
    wait_drain(60);

    // 3: saturating negate boundaries
    fill_random(8);
    for (int k = 0; k < 8; k++) slot_addr[k] = AW'(k);
    slot_im[0] = 16'h8000; slot_b[0] = 1'b1;
    slot_im[1] = 16'h8000; slot_b[1] = 1'b0;
    slot_im[2] = 16'h7FFF; slot_b[2] = 1'b1;
    slot_im[3] = 16'h0000; slot_b[3] = 1'b1;
    run_slots(8);
    wait_drain(60);

    // 4: both banks full under backpressure
    out_rdy = 1'b0;
    fill_random(16);
    run_slots(16);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rdy_both_full", rarg_rdy, 0);
      chk("head_held", out_vld, 1);
    end
    @(posedge clk); #1;
    out_rdy = 1'b1;
    found = 1'b0; c = 0;
    while (!found && c < 40) begin
      @(negedge clk);
      if (out_vld && out_last) begin
        found = 1'b1;
        chk("rdy_at_last", rarg_rdy, 0);
      end
      c++;
    end
    chk("bank0_last_seen", found, 1);
    @(negedge clk);
    chk("rdy_after_last", rarg_rdy, 1);
    @(posedge clk); #1;
    wait_drain(60);

    // 5: random backpressure while the second bank fills
    rdy_mode = 1;
    fill_random(16);
    run_slots(16);
    wait_drain(400);
    rdy_mode = 0;
    out_rdy = 1'b1;
    repeat (3) step();

    // 6: reset mid-fill discards the partial bank
    fill_random(8);
    run_slots(5);
    #2 rst_n = 1'b0;
    fill_n = 0;
    expq.delete();
    @(negedge clk);
    chk("mid_rst_out_vld", out_vld, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_out_re", out_re, 0);
    chk("mid_rst_out_im", out_im, 0);
    chk("mid_rst_rdy", rarg_rdy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); chk("mid_rel_rdy0", rarg_rdy, 0);
    @(negedge clk); chk("mid_rel_rdy1", rarg_rdy, 1);
    @(posedge clk); #1;
    fill_random(8);
    run_slots(8);
    wait_drain(60);
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
